// File: rtl/uart_rx_if.sv
// Receiver-side bundle for the uart_rx link: serial line in, byte/strobe/status out.
// Carries parity_err only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport slave  (input rx, output data_out, valid, busy, frame_err, parity_err);
  modport master (output rx, input data_out, valid, busy, frame_err, parity_err);
`else
  modport slave  (input rx, output data_out, valid, busy, frame_err);
  modport master (output rx, input data_out, valid, busy, frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, framing-error flag.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 57600
) (
  input  logic     clk,
  input  logic     rstn,
  uart_rx_if.slave bus
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  // IDLE wait start | START mid-start check | DATA 8 bits | PARITY 9th bit | STOP | BREAK wait line high
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  logic             r_sync1;
  logic             r_rx_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic             r_parity;
  logic             r_parity_err;
`endif

  logic w_bit_end;
  logic w_half_end;

  assign w_bit_end  = (r_cnt == BIT_LAST);
  assign w_half_end = (r_cnt == HALF_LAST);

  assign bus.data_out  = r_data;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity     <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state <= ST_DATA;
              r_idx   <= 3'd0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_parity <= r_rx_s;
            r_state  <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          // Leaving at mid-stop-bit lets an immediately following start edge be caught.
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (^{r_shift, r_parity}) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
`else
              r_data  <= r_shift;
              r_valid <= 1'b1;
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (r_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clk per bit; each task drives one scenario and checks inline.
// Also builds with UART_RX_PARITY_EN, where every frame carries an even-parity bit.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Start edge driven just after edge k; valid is registered on edge k + NBITS*CPB - 2.
  localparam int VALID_LAT = NBITS * CPB - 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  uart_rx_if bus ();

  uart_rx #(
    .CLOCK_FREQ(1_000_000),
    .BAUD      (100_000)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         last_valid_cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
      got_q.push_back(bus.data_out);
    end
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (bus.parity_err) perr_cnt <= perr_cnt + 1;
`endif
    if (bus.valid && bus.frame_err) both_cnt <= both_cnt + 1;
    if ((bus.valid && prev_valid) || (bus.frame_err && prev_ferr)) wide_cnt <= wide_cnt + 1;
    prev_valid <= bus.valid;
    prev_ferr  <= bus.frame_err;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Called and returned at (posedge + 1). Leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                            output logic busy_ok);
    logic bits[NBITS];
    busy_ok = 1'b1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_bad;
    bits[10] = stop;
`else
    bits[9] = stop;
`endif
    start_cyc = cyc;
    for (int b = 0; b < NBITS; b++) begin
      bus.rx = bits[b];
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (!bus.busy) busy_ok = 1'b0;
      repeat (CPB - CPB / 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: data_out=%h valid=%b busy=%b frame_err=%b, want 00 0 0 0",
               bus.data_out, bus.valid, bus.busy, bus.frame_err);
    end
`ifdef UART_RX_PARITY_EN
    tests_run++;
    if (bus.parity_err !== 1'b0) begin
      failed++;
      $display("FAIL reset_parity_err: got %b want 0", bus.parity_err);
    end
`endif
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    int   v0, f0;
    logic bok;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, bok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      failed++;
      $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0);
    end
    tests_run++;
    if (bus.data_out !== 8'hA5) begin
      failed++;
      $display("FAIL single_data: got %h want a5", bus.data_out);
    end
    tests_run++;
    if (last_valid_cyc - start_cyc !== VALID_LAT) begin
      failed++;
      $display("FAIL single_latency: got %0d want %0d", last_valid_cyc - start_cyc, VALID_LAT);
    end
    tests_run++;
    if (ferr_cnt - f0 !== 0) begin
      failed++;
      $display("FAIL single_frame_err: got %0d pulses want 0", ferr_cnt - f0);
    end
    tests_run++;
    if (bok !== 1'b1) begin
      failed++;
      $display("FAIL single_busy_during: busy dropped inside frame, got %b want 1", bok);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      failed++;
      $display("FAIL single_busy_after: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_false_start();
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      failed++;
      $display("FAIL false_start_detect: busy got %b want 1", bus.busy);
    end
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      failed++;
      $display("FAIL false_start_idle: busy got %b want 0", bus.busy);
    end
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin
      failed++;
      $display("FAIL false_start_pulses: valid=%0d frame_err=%0d want 0 0",
               valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int   v0, f0;
    logic bok;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, bok);
    tests_run++;
    if (ferr_cnt - f0 !== 1 || valid_cnt - v0 !== 0) begin
      failed++;
      $display("FAIL ferr_pulse: frame_err=%0d valid=%0d want 1 0", ferr_cnt - f0, valid_cnt - v0);
    end
    tests_run++;
    if (bus.data_out !== 8'hA5) begin
      failed++;
      $display("FAIL ferr_data_hold: got %h want a5", bus.data_out);
    end
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b1 || ferr_cnt - f0 !== 1) begin
      failed++;
      $display("FAIL ferr_break_hold: busy=%b frame_err=%0d want 1 1", bus.busy, ferr_cnt - f0);
    end
    bus.rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || valid_cnt - v0 !== 0) begin
      failed++;
      $display("FAIL ferr_release: busy=%b valid=%0d want 0 0", bus.busy, valid_cnt - v0);
    end
  endtask

  task automatic test_back_to_back();
    int   v0, f0, n0;
    logic bok;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    n0 = got_q.size();
    send_frame(8'h00, 1'b1, 1'b0, bok);
    send_frame(8'hFF, 1'b1, 1'b0, bok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 2 || ferr_cnt - f0 !== 0) begin
      failed++;
      $display("FAIL b2b_count: valid=%0d frame_err=%0d want 2 0", valid_cnt - v0, ferr_cnt - f0);
    end
    tests_run++;
    if (got_q.size() < n0 + 2 || got_q[n0] !== 8'h00 || got_q[n0+1] !== 8'hFF) begin
      failed++;
      $display("FAIL b2b_data: got %0d bytes, first=%h second=%h want 00 ff",
               got_q.size() - n0, (got_q.size() > n0) ? got_q[n0] : 8'hxx,
               (got_q.size() > n0 + 1) ? got_q[n0+1] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   v0, f0;
    logic bok;
    logic [7:0] d;
    d  = 8'h5A;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    bus.rx = d[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.data_out !== 8'h00 || bus.valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_async: busy=%b data_out=%h valid=%b want 0 00 0",
               bus.busy, bus.data_out, bus.valid);
    end
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0 || bus.busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_discard: valid=%0d frame_err=%0d busy=%b want 0 0 0",
               valid_cnt - v0, ferr_cnt - f0, bus.busy);
    end
    send_frame(8'h5A, 1'b1, 1'b0, bok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 1 || bus.data_out !== 8'h5A) begin
      failed++;
      $display("FAIL reset_mid_next: valid=%0d data_out=%h want 1 5a", valid_cnt - v0, bus.data_out);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int   v0, p0;
    logic bok;
    v0 = valid_cnt;
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0, bok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 1 || bus.data_out !== 8'h07 || perr_cnt - p0 !== 0) begin
      failed++;
      $display("FAIL parity_good: valid=%0d data_out=%h parity_err=%0d want 1 07 0",
               valid_cnt - v0, bus.data_out, perr_cnt - p0);
    end
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1, bok);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (valid_cnt - v0 !== 0 || perr_cnt - p0 !== 1 || bus.data_out !== 8'h07) begin
      failed++;
      $display("FAIL parity_bad: valid=%0d parity_err=%0d data_out=%h want 0 1 07",
               valid_cnt - v0, perr_cnt - p0, bus.data_out);
    end
  endtask
`endif

  task automatic test_pulse_rules();
    tests_run++;
    if (both_cnt !== 0 || wide_cnt !== 0) begin
      failed++;
      $display("FAIL pulse_rules: overlap=%0d wide=%0d want 0 0", both_cnt, wide_cnt);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receives 8N1 asynchronous serial frames on rx: start bit, 8 data bits LSB-first, stop bit.
- Presents each received byte on a parallel output with a one-cycle valid strobe.
- It is the receiving end of the uart_tx link and uses the same CLOCK_FREQ/BAUD timing convention.
- It samples each bit at its midpoint, rejects false starts, and flags framing errors.

Parameters:
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 57600, line bit rate.
- Derived (localparam): CYCLES_PER_BIT = CLOCK_FREQ/BAUD (truncating); HALF_BIT = CYCLES_PER_BIT/2.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse: new byte on data_out.
- busy  output  1  high while a frame is being received.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset values: data_out=8'h00, valid=0, busy=0, frame_err=0, FSM=IDLE, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. The synchronizer adds 2 cycles of detection latency.
- Cycle counter width: $clog2(CYCLES_PER_BIT)+1 bits. Bit index: 0..7.
- IDLE:
  - busy=0.
  - rx_s==0 → START, cycle_cnt=0.
- START:
  - Count to HALF_BIT-1, then sample rx_s.
  - rx_s==0 → DATA, cycle_cnt=0, index=0.
  - rx_s==1 → false start; return to IDLE with no output pulse.
- DATA:
  - Count to CYCLES_PER_BIT-1, then sample rx_s into shift_reg[index]. Data is LSB-first, so index 0 is the first data bit.
  - After index 7 is sampled → STOP (or PARITY when enabled), cycle_cnt=0.
- STOP:
  - Count to CYCLES_PER_BIT-1, then sample rx_s.
  - rx_s==1 → data_out<=shift_reg; valid=1 for exactly one cycle (the cycle after the sample edge); go to IDLE.
  - rx_s==0 → frame_err=1 for one cycle; data_out unchanged; valid stays 0; go to BREAK.
- BREAK:
  - Wait until rx_s==1, then go to IDLE.
  - Prevents a held-low line from retriggering START.
- busy: high in START, DATA, PARITY, STOP and BREAK.
- Handshake: there is no backpressure. valid is a strobe. data_out holds until the next good frame. A byte not consumed is overwritten by the next frame.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge that immediately follows the stop bit is detected.
- Reset mid-frame: all state and outputs return immediately to their reset values. The partial frame is discarded and produces no pulses.
- valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP. It lasts one full bit period and samples the 9th bit.
  - Even parity is expected, i.e. XOR of the 8 data bits and the parity bit = 0.
  - Adds output parity_err (1 bit, resets 0), pulsed for one cycle with the STOP decision when the parity mismatches.
  - On a parity mismatch with a good stop bit: parity_err=1, valid=0, data_out unchanged.
- When not defined:
  - There is no PARITY state and no parity_err port.
  - The frame is plain 8N1 as described above.

Test Plan (CLOCK_FREQ=1_000_000, BAUD=100_000 → CYCLES_PER_BIT=10, HALF_BIT=5):
- Drive a clean 8N1 frame of 0xA5, 10 clk per bit → data_out=0xA5, valid high exactly 1 cycle about 97 clk after the start edge, frame_err=0, busy high throughout the frame.
- Drive rx low for 3 clk then high → no valid, no frame_err; FSM back in IDLE and busy=0 within 8 clk.
- Frame 0x3C with stop bit driven low, rx held low 30 clk then high → frame_err one-cycle pulse, valid=0, data_out retains its prior value; no new frame is started until rx returns high.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two valid pulses with data_out=0x00, then 0xFF.
- Assert rstn low during data bit 4 of a frame, release, then send 0x5A → no output pulses from the aborted frame; the next frame yields data_out=0x5A.
- UART_RX_PARITY_EN defined: send 0x07 with parity 1 → valid, data_out=0x07. Send 0x07 with parity 0 → parity_err pulse, valid=0.
